cpu_host_loader: RTL and testbench

Host-side controller for the CPU's external memory ports. Streams a program into instruction memory and optionally reads it back to verify it. Then enables the CPU for a programmed number of cycles and streams a window of data memory back out. It sits between a testbench or host link and the CPU top: it drives `addr_ext`/`wen_ext`/`ren_ext`/`wdata_ext`, the `*_2` counterparts and `enable`, and consumes `rdata_ext`/`rdata_ext_2`.

---
 rtl/cpu_host_loader.sv | 248 ++++++++++++++++++++++++
 tb/tb_cpu_host_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_host_loader.sv
// cpu_host_loader
//   Host-side controller for the CPU's external memory ports. A session
//   streams a program into IMEM and can optionally verify it. It then enables
//   the CPU for a fixed number of cycles and streams a window of DMEM back out.
//
//   Optional feature macro: LOADER_VERIFY_EN
//     defined   -> IMEM readback with XOR checksum compare, sticky `error`
//     undefined -> no verify states, `error` tied low
//
// Ports
//   clk, arst_n                  clock, asynchronous active-low reset
//   start                        begin a session (sampled only in IDLE)
//   prog_words/run_cycles/dump_words
//                                session counts, latched with `start`
//   in_valid/in_ready/in_data    32-bit program word stream
//   out_valid/out_ready/out_data 64-bit dump stream
//   addr_ext..rdata_ext          IMEM external port (1-cycle read latency)
//   addr_ext_2..rdata_ext_2      DMEM external port (read only)
//   cpu_enable                   CPU enable during RUN
//   busy, done, error            status (done is a one-cycle pulse)
module cpu_host_loader #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] prog_words,
  input  logic [CNT_W-1:0] run_cycles,
  input  logic [CNT_W-1:0] dump_words,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [63:0]      addr_ext,
  output logic             wen_ext,
  output logic             ren_ext,
  output logic [31:0]      wdata_ext,
  input  logic [31:0]      rdata_ext,
  output logic [63:0]      addr_ext_2,
  output logic             wen_ext_2,
  output logic             ren_ext_2,
  output logic [63:0]      wdata_ext_2,
  input  logic [63:0]      rdata_ext_2,
  output logic             cpu_enable,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
`ifdef LOADER_VERIFY_EN
    VERIFY_RD,
    VERIFY_CMP,
`endif
    RUN,
    DUMP_RD,
    DUMP_WAIT,
    DUMP_OUT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] idx_inc;
  logic [CNT_W-1:0] prog_cnt;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] dump_cnt;
  logic [63:0]      out_data_q;
  logic             in_hs;
  logic             load_last;
  logic [63:0]      imem_addr;
  logic [63:0]      dmem_addr;

  assign idx_inc   = idx + 1'b1;
  assign in_hs     = (state == LOAD) && in_valid && (idx != prog_cnt);
  assign load_last = in_hs && (idx_inc == prog_cnt);
  assign imem_addr = {{(62-CNT_W){1'b0}}, idx, 2'b00};
  assign dmem_addr = {{(61-CNT_W){1'b0}}, idx, 3'b000};

`ifdef LOADER_VERIFY_EN
  logic [31:0] load_sum;
  logic [31:0] rb_sum;
  logic        error_q;
`endif

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------- next state
  // Zero counts skip their phase outright, so a session with all counts zero
  // spends exactly one cycle in LOAD and then goes straight to DONE.
  state_t after_load;
  state_t after_run;

  always_comb begin
    after_run  = (dump_cnt != '0) ? DUMP_RD : DONE;
    after_load = (run_cnt != '0) ? RUN : after_run;
    state_nx   = state;
    unique case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (prog_cnt == '0) begin
          state_nx = after_load;
        end else if (load_last) begin
`ifdef LOADER_VERIFY_EN
          state_nx = VERIFY_RD;
`else
          state_nx = after_load;
`endif
        end
      end
`ifdef LOADER_VERIFY_EN
      VERIFY_RD:  state_nx = VERIFY_CMP;
      VERIFY_CMP: state_nx = (idx_inc == prog_cnt) ? after_load : VERIFY_RD;
`endif
      RUN:        if (idx_inc == run_cnt) state_nx = after_run;
      DUMP_RD:    state_nx = DUMP_WAIT;
      DUMP_WAIT:  state_nx = DUMP_OUT;
      DUMP_OUT: begin
        if (out_ready) state_nx = (idx_inc == dump_cnt) ? DONE : DUMP_RD;
      end
      DONE:       state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  // A single index serves every phase; it returns to zero on each phase exit.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      idx        <= '0;
      prog_cnt   <= '0;
      run_cnt    <= '0;
      dump_cnt   <= '0;
      out_data_q <= '0;
`ifdef LOADER_VERIFY_EN
      load_sum   <= '0;
      rb_sum     <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          idx <= '0;
          if (start) begin
            prog_cnt <= prog_words;
            run_cnt  <= run_cycles;
            dump_cnt <= dump_words;
`ifdef LOADER_VERIFY_EN
            load_sum <= '0;
            rb_sum   <= '0;
            error_q  <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (in_hs) begin
            idx <= load_last ? '0 : idx_inc;
`ifdef LOADER_VERIFY_EN
            load_sum <= load_sum ^ in_data;
`endif
          end
        end
`ifdef LOADER_VERIFY_EN
        VERIFY_CMP: begin
          // rdata_ext holds the word addressed during the preceding VERIFY_RD.
          rb_sum <= rb_sum ^ rdata_ext;
          if (idx_inc == prog_cnt) begin
            idx <= '0;
            if (load_sum != (rb_sum ^ rdata_ext)) error_q <= 1'b1;
          end else begin
            idx <= idx_inc;
          end
        end
`endif
        RUN: idx <= (idx_inc == run_cnt) ? '0 : idx_inc;
        DUMP_WAIT: out_data_q <= rdata_ext_2;
        DUMP_OUT: begin
          if (out_ready) idx <= (idx_inc == dump_cnt) ? '0 : idx_inc;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    addr_ext   = '0;
    wen_ext    = 1'b0;
    ren_ext    = 1'b0;
    wdata_ext  = '0;
    addr_ext_2 = '0;
    ren_ext_2  = 1'b0;
    cpu_enable = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      LOAD: begin
        in_ready = (idx != prog_cnt);
        if (in_hs) begin
          wen_ext   = 1'b1;
          addr_ext  = imem_addr;
          wdata_ext = in_data;
        end
      end
`ifdef LOADER_VERIFY_EN
      VERIFY_RD: begin
        ren_ext  = 1'b1;
        addr_ext = imem_addr;
      end
`endif
      RUN:      cpu_enable = 1'b1;
      DUMP_RD: begin
        ren_ext_2  = 1'b1;
        addr_ext_2 = dmem_addr;
      end
      DUMP_OUT: out_valid = 1'b1;
      DONE:     done      = 1'b1;
      default: ;
    endcase
  end

  assign out_data    = out_data_q;
  assign wen_ext_2   = 1'b0;
  assign wdata_ext_2 = '0;

`ifdef LOADER_VERIFY_EN
  assign error = error_q;
`else
  assign error = 1'b0;
  logic unused_rdata;
  assign unused_rdata = ^rdata_ext;
`endif

endmodule

// File: tb/tb_cpu_host_loader.sv
module tb_cpu_host_loader;

  localparam int unsigned CNT_W = 16;
`ifdef LOADER_VERIFY_EN
  localparam int VER_PER_WORD = 2;
`else
  localparam int VER_PER_WORD = 0;
`endif

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] prog_words = '0;
  logic [CNT_W-1:0] run_cycles = '0;
  logic [CNT_W-1:0] dump_words = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [63:0]      out_data;
  logic [63:0]      addr_ext;
  logic             wen_ext;
  logic             ren_ext;
  logic [31:0]      wdata_ext;
  logic [31:0]      rdata_ext = '0;
  logic [63:0]      addr_ext_2;
  logic             wen_ext_2;
  logic             ren_ext_2;
  logic [63:0]      wdata_ext_2;
  logic [63:0]      rdata_ext_2 = '0;
  logic             cpu_enable;
  logic             busy;
  logic             done;
  logic             error;

  int n_checks = 0;
  int n_pass   = 0;

  logic        corrupt = 1'b0;
  logic [31:0] imem [0:15];
  logic [63:0] dmem [0:15];

  cpu_host_loader #(.CNT_W(CNT_W)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .prog_words(prog_words), .run_cycles(run_cycles), .dump_words(dump_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
    .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
    .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
    .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
    .cpu_enable(cpu_enable), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Memory models with 1-cycle read latency; corrupt flips bit 0 of word 1.
  always @(posedge clk) begin
    if (wen_ext) imem[addr_ext[5:2]] <= wdata_ext;
    if (ren_ext) rdata_ext <= imem[addr_ext[5:2]] ^
                              ((corrupt && addr_ext[5:2] == 4'd1) ? 32'h1 : 32'h0);
    if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[6:3]];
  end

  task automatic test_reset;
    @(negedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 64'h0) $display("FAIL reset_out_data got %h exp 0", out_data); else n_pass++;
    n_checks++; if (cpu_enable !== 1'b0) $display("FAIL reset_cpu_enable got %b exp 0", cpu_enable); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error got %b exp 0", error); else n_pass++;
    n_checks++;
    if ({wen_ext, ren_ext, ren_ext_2, wen_ext_2} !== 4'b0 || addr_ext !== 64'h0 || addr_ext_2 !== 64'h0 ||
        wdata_ext !== 32'h0 || wdata_ext_2 !== 64'h0)
      $display("FAIL reset_ext_port strobes %b addr %h addr2 %h exp all 0",
               {wen_ext, ren_ext, ren_ext_2, wen_ext_2}, addr_ext, addr_ext_2);
    else n_pass++;
    @(negedge clk); arst_n = 1'b1;
  endtask

  task automatic test_full_session;
    logic [31:0] words [0:2];
    logic [63:0] exp_out [0:1];
    int nw = 0, n_en = 0, nout = 0, stall = 0, ndone = 0;
    int last_wen = -1, first_en = -1, last_en = -1, first_ren2 = -1, first_rdy = -1;
    words[0] = 32'h00500093; words[1] = 32'h00A00113; words[2] = 32'h002081B3;
    exp_out[0] = 64'h11; exp_out[1] = 64'h22;
    @(negedge clk);
    start = 1'b1; prog_words = 16'd3; run_cycles = 16'd5; dump_words = 16'd2;
    in_valid = 1'b1; in_data = words[0];
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b exp 0", busy); else n_pass++;
    for (int cy = 1; cy <= 40; cy++) begin
      @(negedge clk);
      start = 1'b0;
      in_data = (nw < 3) ? words[nw] : 32'h0;
      out_ready = (nout > 0) || (stall >= 4);
      #1;
      if (in_ready && first_rdy < 0) first_rdy = cy;
      if (wen_ext) begin
        n_checks++;
        if (addr_ext !== 64'(4 * nw)) $display("FAIL load_addr w%0d got %h exp %h", nw, addr_ext, 4 * nw);
        else n_pass++;
        n_checks++;
        if (nw > 2 || wdata_ext !== words[nw]) $display("FAIL load_wdata w%0d got %h", nw, wdata_ext);
        else n_pass++;
        nw++; last_wen = cy;
      end
      if (cpu_enable) begin
        if (first_en < 0) first_en = cy;
        n_en++; last_en = cy;
      end
      if (ren_ext_2 && first_ren2 < 0) first_ren2 = cy;
      if (out_valid && !out_ready) begin
        n_checks++;
        if (out_data !== 64'h11) $display("FAIL dump_hold got %h exp 11", out_data); else n_pass++;
        stall++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (nout > 1 || out_data !== exp_out[nout]) $display("FAIL dump_data w%0d got %h", nout, out_data);
        else n_pass++;
        nout++;
      end
      if (done) begin
        ndone++;
        n_checks++; if (error !== 1'b0) $display("FAIL session_error got %b exp 0", error); else n_pass++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++; if (first_rdy !== 1) $display("FAIL start_to_ready got %0d exp 1", first_rdy); else n_pass++;
    n_checks++; if (nw !== 3) $display("FAIL load_count got %0d exp 3", nw); else n_pass++;
    n_checks++; if (n_en !== 5) $display("FAIL run_cycles got %0d exp 5", n_en); else n_pass++;
    n_checks++;
    if (first_en !== last_wen + 1 + VER_PER_WORD * 3)
      $display("FAIL run_latency got %0d exp %0d", first_en, last_wen + 1 + VER_PER_WORD * 3);
    else n_pass++;
    n_checks++;
    if (first_ren2 !== last_en + 1) $display("FAIL dump_latency got %0d exp %0d", first_ren2, last_en + 1);
    else n_pass++;
    n_checks++; if (stall !== 4) $display("FAIL dump_stall got %0d exp 4", stall); else n_pass++;
    n_checks++; if (nout !== 2) $display("FAIL dump_count got %0d exp 2", nout); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL done_pulses got %0d exp 1", ndone); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL end_busy got %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_zero_counts;
    int nbusy = 0, ndone = 0, nstrobe = 0, done_cy = -1;
    @(negedge clk);
    start = 1'b1; prog_words = '0; run_cycles = '0; dump_words = '0; in_valid = 1'b1;
    for (int cy = 1; cy <= 6; cy++) begin
      @(negedge clk); start = 1'b0; #1;
      if (busy) nbusy++;
      if (done) begin ndone++; done_cy = cy; end
      if (wen_ext || ren_ext || ren_ext_2 || cpu_enable || in_ready || out_valid) nstrobe++;
    end
    in_valid = 1'b0;
    n_checks++; if (nbusy !== 2) $display("FAIL zero_busy got %0d exp 2", nbusy); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL zero_done got %0d exp 1", ndone); else n_pass++;
    n_checks++; if (done_cy !== 2) $display("FAIL zero_done_cycle got %0d exp 2", done_cy); else n_pass++;
    n_checks++; if (nstrobe !== 0) $display("FAIL zero_strobes got %0d exp 0", nstrobe); else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int n_en = 0, nw = 0, ndone = 0, nout = 0;
    logic [31:0] w [0:1];
    w[0] = 32'hCAFE0001; w[1] = 32'hCAFE0002;
    @(negedge clk);
    start = 1'b1; prog_words = 16'd1; run_cycles = 16'd5; dump_words = '0;
    in_valid = 1'b1; in_data = 32'h12345678;
    for (int cy = 1; cy <= 12 && n_en < 2; cy++) begin
      @(negedge clk); start = 1'b0; #1;
      if (cpu_enable) n_en++;
    end
    n_checks++; if (n_en !== 2) $display("FAIL reach_run2 got %0d exp 2", n_en); else n_pass++;
    arst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++; if (cpu_enable !== 1'b0) $display("FAIL async_enable got %b exp 0", cpu_enable); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL async_busy got %b exp 0", busy); else n_pass++;
    @(negedge clk); @(negedge clk); arst_n = 1'b1;
    // Full session afterwards, with in_valid gapped to exercise load stalls.
    @(negedge clk);
    start = 1'b1; prog_words = 16'd2; run_cycles = 16'd3; dump_words = 16'd1;
    n_en = 0; out_ready = 1'b1;
    for (int cy = 1; cy <= 30; cy++) begin
      @(negedge clk);
      start = 1'b0;
      in_valid = cy[0];
      in_data = (nw < 2) ? w[nw] : 32'h0;
      #1;
      if (wen_ext) begin
        n_checks++;
        if (!cy[0] || addr_ext !== 64'(4 * nw) || wdata_ext !== in_data)
          $display("FAIL stall_write cy%0d addr %h data %h exp addr %h", cy, addr_ext, wdata_ext, 4 * nw);
        else n_pass++;
        nw++;
      end
      if (cpu_enable) n_en++;
      if (out_valid) begin
        n_checks++; if (out_data !== 64'h11) $display("FAIL rerun_dump got %h exp 11", out_data); else n_pass++;
        nout++;
      end
      if (done) ndone++;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++; if (nw !== 2) $display("FAIL rerun_writes got %0d exp 2", nw); else n_pass++;
    n_checks++; if (imem[1] !== 32'hCAFE0002) $display("FAIL rerun_imem1 got %h exp cafe0002", imem[1]); else n_pass++;
    n_checks++; if (n_en !== 3) $display("FAIL rerun_enable got %0d exp 3", n_en); else n_pass++;
    n_checks++; if (nout !== 1) $display("FAIL rerun_outs got %0d exp 1", nout); else n_pass++;
    n_checks++; if (ndone !== 1) $display("FAIL rerun_done got %0d exp 1", ndone); else n_pass++;
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify_error;
    int ndone = 0;
    corrupt = 1'b1;
    @(negedge clk);
    start = 1'b1; prog_words = 16'd3; run_cycles = '0; dump_words = '0; in_valid = 1'b1;
    for (int cy = 1; cy <= 15; cy++) begin
      @(negedge clk); start = 1'b0; in_data = 32'h1000 + 32'(cy); #1;
      if (done) begin
        ndone++;
        n_checks++; if (error !== 1'b1) $display("FAIL verify_error_done got %b exp 1", error); else n_pass++;
      end
    end
    n_checks++; if (ndone !== 1) $display("FAIL verify_done got %0d exp 1", ndone); else n_pass++;
    n_checks++; if (error !== 1'b1) $display("FAIL verify_sticky got %b exp 1", error); else n_pass++;
    corrupt = 1'b0;
    @(negedge clk);
    start = 1'b1; prog_words = 16'd1;
    @(negedge clk); start = 1'b0; #1;
    n_checks++; if (error !== 1'b0) $display("FAIL verify_clear got %b exp 0", error); else n_pass++;
    for (int cy = 1; cy <= 8; cy++) @(negedge clk);
    #1;
    n_checks++; if (error !== 1'b0) $display("FAIL verify_clean got %b exp 0", error); else n_pass++;
    in_valid = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 64'hDEAD_0000 + 64'(i);
    end
    dmem[0] = 64'h11;
    dmem[1] = 64'h22;
    test_reset();
    test_full_session();
    test_zero_counts();
    test_reset_mid_run();
`ifdef LOADER_VERIFY_EN
    test_verify_error();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
